// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-ported word RAM with a one-cycle read latency.
// Handles byte/half/word access, sign or zero extension, and sub-word stores by read-modify-write.
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          MemWrite,
  input  logic          MemtoReg,
  input  logic          Memrhalf,
  input  logic          Memrbyte,
  input  logic          MemExt,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          misalign,
  output logic          busy,
  output logic [AW-3:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    RMW_RD,
    RMW_RDW,
    RESP
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          byte_q;
  logic          half_q;
  logic          ext_q;
  logic          misal_q;

  // A simultaneous write+read request is a write; half+byte together is a byte access.
  logic req_write, req_read, req_byte, req_half, req_word, req_misal;

  always_comb begin
    req_write = MemWrite;
    req_read  = MemtoReg & ~MemWrite;
    req_byte  = Memrbyte;
    req_half  = Memrhalf & ~Memrbyte;
    req_word  = ~Memrbyte & ~Memrhalf;
    req_misal = (req_write | req_read) &
                ((req_half & addr[0]) | (req_word & (addr[1:0] != 2'b00)));
  end

  // Lane extraction and merge are both shifts by the latched byte offset.
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane_data  = mem_rdata >> lane_shift;
    lane_mask  = byte_q ? (32'h0000_00FF << lane_shift) : (32'h0000_FFFF << lane_shift);
    if (byte_q)
      load_val = {{24{ext_q & lane_data[7]}}, lane_data[7:0]};
    else if (half_q)
      load_val = {{16{ext_q & lane_data[15]}}, lane_data[15:0]};
    else
      load_val = mem_rdata;
    merged = (mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      ext_q   <= 1'b0;
      misal_q <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            byte_q  <= req_byte;
            half_q  <= req_half;
            ext_q   <= MemExt;
            misal_q <= req_misal;
          end
        end
        RDW:     rdata   <= load_val;
        RMW_RDW: wdata_q <= merged;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    misalign   = 1'b0;
    busy       = (state != IDLE);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state != IDLE)
      mem_addr = addr_q[AW-1:2];
    case (state)
      IDLE: begin
        if (req) begin
          if (req_misal)
            state_next = RESP;
          else if (req_write)
            state_next = req_word ? WR : RMW_RD;
          else if (req_read)
            state_next = RD;
          else
            state_next = RESP;
        end
      end
      RD:      state_next = RDW;
      RDW:     state_next = RESP;
      RMW_RD:  state_next = RMW_RDW;
      RMW_RDW: state_next = WR;
      WR: begin
        mem_we     = 1'b1;
        mem_wdata  = wdata_q;
        state_next = RESP;
      end
      RESP: begin
        done       = 1'b1;
        misalign   = misal_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset corner cases,
// then random accesses checked against a byte-lane reference model of memory and rdata.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        MemWrite, MemtoReg, Memrhalf, Memrbyte, MemExt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done, misalign, busy;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.AW(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .Memrhalf(Memrhalf), .Memrbyte(Memrbyte), .MemExt(MemExt),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .misalign(misalign), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM with registered read data; only the low 64 words are used.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr[5:0]];
    if (mem_we) ram[mem_addr[5:0]] = mem_wdata;
  end

  logic [31:0] model_mem [64];
  logic [31:0] model_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] act_rd;
  int          act_lat;
  logic        act_mis;
  int          act_wes;

  typedef struct {
    string       name;
    logic        w, r, h, b, e;
    logic [31:0] a, wd, exp_rd;
    int          exp_lat;
    logic        exp_mis;
    int          exp_we;
  } vec_t;

  function automatic vec_t mk(string n, logic w, logic r, logic h, logic b, logic e,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              int lat, logic mis, int we);
    vec_t v;
    v.name = n; v.w = w; v.r = r; v.h = h; v.b = b; v.e = e;
    v.a = a; v.wd = wd; v.exp_rd = rd; v.exp_lat = lat; v.exp_mis = mis; v.exp_we = we;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: applies one access to model_mem/model_rdata using byte-lane arithmetic.
  task automatic modelAccess(input logic w, input logic r, input logic h, input logic b,
                             input logic [31:0] a, input logic [31:0] wd, input logic e,
                             output int lat, output logic mis, output int wes);
    int          sz, off, idx;
    logic [31:0] mask, v, word;
    logic        is_w, is_r;
    is_w = w;
    is_r = r & ~w;
    sz   = b ? 1 : (h ? 2 : 4);
    off  = int'(a[1:0]);
    idx  = int'(a[7:2]);
    mask = (sz == 1) ? 32'hFF : ((sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
    mis  = (is_w || is_r) && ((off % sz) != 0);
    wes  = 0;
    if (mis || !(is_w || is_r)) begin
      lat = 1;
    end else if (is_r) begin
      word = model_mem[idx];
      v    = (word >> (8 * off)) & mask;
      if (e && v[8 * sz - 1]) v = v | ~mask;
      model_rdata = v;
      lat = 3;
    end else begin
      word = model_mem[idx];
      model_mem[idx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      lat = (sz == 4) ? 2 : 4;
      wes = 1;
    end
  endtask

  task automatic applyStimulus(input string name, input logic w, input logic r, input logic h,
                               input logic b, input logic e, input logic [31:0] a,
                               input logic [31:0] wd);
    int          exp_lat, exp_wes, stray;
    logic        exp_mis, busy_c1;
    logic [29:0] we_addr;
    logic [31:0] we_data;
    modelAccess(w, r, h, b, a, wd, e, exp_lat, exp_mis, exp_wes);
    @(negedge clk);
    MemWrite = w; MemtoReg = r; Memrhalf = h; Memrbyte = b; MemExt = e;
    addr = a; wdata = wd; req = 1'b1;
    act_lat = 0; act_mis = 1'b0; act_wes = 0; stray = 0;
    busy_c1 = 1'b0; we_addr = '0; we_data = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) busy_c1 = busy;
      if (mem_we) begin
        act_wes++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (!done && misalign) stray++;
      if (done) begin
        act_lat = c;
        act_mis = misalign;
        break;
      end
    end
    req = 1'b0;
    act_rd = rdata;
    checkOutput({name, " latency"}, 32'(act_lat), 32'(exp_lat));
    checkOutput({name, " misalign"}, 32'(act_mis), 32'(exp_mis));
    checkOutput({name, " we_pulses"}, 32'(act_wes), 32'(exp_wes));
    checkOutput({name, " rdata"}, act_rd, model_rdata);
    checkOutput({name, " busy_c1"}, 32'(busy_c1), 32'h1);
    checkOutput({name, " stray_misalign"}, 32'(stray), 32'h0);
    if (exp_wes == 1) begin
      checkOutput({name, " we_addr"}, 32'(we_addr), {2'b00, a[31:2]});
      checkOutput({name, " we_data"}, we_data, model_mem[a[7:2]]);
    end
    @(negedge clk);
    checkOutput({name, " done_cleared"}, 32'(done), 32'h0);
    checkOutput({name, " idle_after"}, 32'(busy), 32'h0);
  endtask

  vec_t tbl [21];

  initial begin
    int          wcount;
    logic        rw, rr, rh, rb, re;
    logic [31:0] ra, rwd;
    int          op, sz;

    tbl[0]  = mk("sw_deadbeef", 1,0,0,0,0, 32'h10, 32'hDEADBEEF, 32'h0000_0000, 2, 0, 1);
    tbl[1]  = mk("lw_10",       0,1,0,0,0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 0, 0);
    tbl[2]  = mk("sw_20a",      1,0,0,0,0, 32'h20, 32'h12345680, 32'hDEADBEEF, 2, 0, 1);
    tbl[3]  = mk("lb_20",       0,1,0,1,1, 32'h20, 32'h0,        32'hFFFFFF80, 3, 0, 0);
    tbl[4]  = mk("lbu_20",      0,1,0,1,0, 32'h20, 32'h0,        32'h00000080, 3, 0, 0);
    tbl[5]  = mk("lb_23",       0,1,0,1,1, 32'h23, 32'h0,        32'h00000012, 3, 0, 0);
    tbl[6]  = mk("sw_20b",      1,0,0,0,0, 32'h20, 32'h80011234, 32'h00000012, 2, 0, 1);
    tbl[7]  = mk("lh_22",       0,1,1,0,1, 32'h22, 32'h0,        32'hFFFF8001, 3, 0, 0);
    tbl[8]  = mk("lhu_22",      0,1,1,0,0, 32'h22, 32'h0,        32'h00008001, 3, 0, 0);
    tbl[9]  = mk("lh_20",       0,1,1,0,1, 32'h20, 32'h0,        32'h00001234, 3, 0, 0);
    tbl[10] = mk("sw_10",       1,0,0,0,0, 32'h10, 32'h11223344, 32'h00001234, 2, 0, 1);
    tbl[11] = mk("sb_13",       1,0,0,1,0, 32'h13, 32'h000000AB, 32'h00001234, 4, 0, 1);
    tbl[12] = mk("lw_10_sb",    0,1,0,0,0, 32'h10, 32'h0,        32'hAB223344, 3, 0, 0);
    tbl[13] = mk("sh_10",       1,0,1,0,0, 32'h10, 32'h0000BEEF, 32'hAB223344, 4, 0, 1);
    tbl[14] = mk("lw_10_sh",    0,1,0,0,0, 32'h10, 32'h0,        32'hAB22BEEF, 3, 0, 0);
    tbl[15] = mk("lw_21_mis",   0,1,0,0,0, 32'h21, 32'h0,        32'hAB22BEEF, 1, 1, 0);
    tbl[16] = mk("sh_11_mis",   1,0,1,0,0, 32'h11, 32'h00001111, 32'hAB22BEEF, 1, 1, 0);
    tbl[17] = mk("null_40",     0,0,0,0,0, 32'h40, 32'h0,        32'hAB22BEEF, 1, 0, 0);
    tbl[18] = mk("wr_and_rd",   1,1,0,0,0, 32'h14, 32'h55AA55AA, 32'hAB22BEEF, 2, 0, 1);
    tbl[19] = mk("lw_14",       0,1,0,0,0, 32'h14, 32'h0,        32'h55AA55AA, 3, 0, 0);
    tbl[20] = mk("lbhu_13",     0,1,1,1,0, 32'h13, 32'h0,        32'h000000AB, 3, 0, 0);

    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      model_mem[i] = ram[i];
    end
    model_rdata = 32'h0;

    rst = 1'b1; req = 1'b0;
    MemWrite = 0; MemtoReg = 0; Memrhalf = 0; Memrbyte = 0; MemExt = 0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset misalign", 32'(misalign), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(tbl[i].name, tbl[i].w, tbl[i].r, tbl[i].h, tbl[i].b, tbl[i].e,
                    tbl[i].a, tbl[i].wd);
      checkOutput({tbl[i].name, " tbl_rdata"}, act_rd, tbl[i].exp_rd);
      checkOutput({tbl[i].name, " tbl_latency"}, 32'(act_lat), 32'(tbl[i].exp_lat));
      checkOutput({tbl[i].name, " tbl_misalign"}, 32'(act_mis), 32'(tbl[i].exp_mis));
      checkOutput({tbl[i].name, " tbl_we"}, 32'(act_wes), 32'(tbl[i].exp_we));
    end

    $display("[TB] reset in the middle of a sub-word store");
    @(negedge clk);
    MemWrite = 1; MemtoReg = 0; Memrhalf = 0; Memrbyte = 1; MemExt = 0;
    addr = 32'h11; wdata = 32'h77; req = 1'b1;
    @(negedge clk);
    checkOutput("abort busy_rmw_rd", 32'(busy), 32'h1);
    @(negedge clk);
    checkOutput("abort busy_rmw_rdw", 32'(busy), 32'h1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort rdata", rdata, 32'h0);
    checkOutput("abort mem_we", 32'(mem_we), 32'h0);
    checkOutput("abort done", 32'(done), 32'h0);
    rst = 1'b0;
    model_rdata = 32'h0;
    wcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we) wcount++;
    end
    checkOutput("abort no_we_after", 32'(wcount), 32'h0);
    checkOutput("abort ram_unchanged", ram[4], model_mem[4]);
    applyStimulus("post_abort_lw", 0, 1, 0, 0, 0, 32'h10, 32'h0);
    checkOutput("post_abort value", act_rd, 32'hAB22BEEF);

    $display("[TB] reset has priority over req");
    @(negedge clk);
    MemWrite = 1; MemtoReg = 0; Memrhalf = 0; Memrbyte = 0;
    addr = 32'h18; wdata = 32'h0BADF00D; req = 1'b1; rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_prio busy", 32'(busy), 32'h0);
    checkOutput("rst_prio mem_we", 32'(mem_we), 32'h0);
    rst = 1'b0; req = 1'b0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_prio ram", ram[6], model_mem[6]);

    $display("[TB] random accesses");
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      sz = $urandom_range(0, 3);
      rh = (sz == 1) || (sz == 3);
      rb = (sz == 2) || (sz == 3);
      re = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 255));
      rwd = $urandom;
      if (op == 0) begin
        rw = 0; rr = 0; ra = ra & 32'hFFFF_FFFC;
      end else if (op <= 4) begin
        rw = 0; rr = 1;
      end else begin
        rw = 1; rr = 1'($urandom_range(0, 1));
      end
      applyStimulus("rand", rw, rr, rh, rb, re, ra, rwd);
    end
    for (int i = 0; i < 64; i++)
      checkOutput("final ram", ram[i], model_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
